fir_ap_ctrl: RTL and testbench
==============================

# fir_ap_ctrl

Control and resource-sharing front end for the FIR engine. Terminates AXI-Lite configuration traffic and holds the ap_ctrl and data_length registers. Arbitrates the single tap-coefficient BRAM port between host accesses and the FIR datapath, and sequences each run with a start pulse and a done handshake. Sits between the AXI-Lite bus and the FIR datapath/tap BRAM.

## Interface
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of tap coefficients
- axis_clk  in  1  single clock; all logic on rising edge
- axis_rst  in  1  asynchronous, active-high reset
- awvalid/awready, wvalid/wready  in/out  1 each  AXI-Lite write handshakes; awaddr in pADDR_WIDTH, wdata in pDATA_WIDTH
- arvalid/arready  in/out  1  read address handshake; araddr in pADDR_WIDTH
- rvalid/rready  out/in  1  read data handshake; rdata out pDATA_WIDTH
- tap_WE out 4, tap_EN out 1, tap_Di out pDATA_WIDTH, tap_A out pADDR_WIDTH (byte address), tap_Do in pDATA_WIDTH  tap BRAM port, 1-cycle read latency
- eng_start  out  1  one-cycle run-start pulse to FIR datapath
- eng_done  in  1  one-cycle pulse from datapath after last output (tlast) accepted
- eng_tap_en  in  1  datapath tap read enable
- eng_tap_A  in  pADDR_WIDTH  datapath tap byte address
- cfg_len  out  pDATA_WIDTH  data_length register value

## Operation
- Register map:
  - 0x00 ap_ctrl: bit0 ap_start (W1 starts; reads 1 while RUN), bit1 ap_done (read-to-clear), bit2 ap_idle.
  - 0x10 data_length.
  - 0x20+4*i tap[i], i < Tape_Num.
  - Other addresses: writes dropped, reads return 0.
- FSM IDLE/RUN; reset -> IDLE.
  - IDLE -> RUN on write to 0x00 with wdata[0]=1 and cfg_len != 0. eng_start=1 in the cycle after the write handshake; ap_idle=0, ap_done=0.
  - ap_start write with cfg_len=0 is ignored: stays IDLE, ap_done unchanged.
  - RUN -> IDLE on eng_done; ap_done=1, ap_idle=1 from the next cycle. eng_done in IDLE is ignored.
- Tap port ownership:
  - IDLE: host owns the port.
  - RUN: datapath owns it. tap_EN=eng_tap_en, tap_A=eng_tap_A, tap_WE=0, combinational pass-through.
- Writes in RUN to 0x10 or the tap range are accepted on the bus but have no effect. Tap reads in RUN return 0xFFFFFFFF and do not touch the BRAM.
- Host tap write: tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20, tap_Di=wdata.
- Host tap read: tap_EN=1, tap_WE=0, tap_A=araddr-0x20; rdata is taken from tap_Do.
- ap_done clears in the cycle rvalid&&rready completes for a read of 0x00. If set and clear coincide, set wins.

## Timing
- Reset values:
  - awready, wready, arready, rvalid, rdata = 0.
  - tap_EN, tap_WE, tap_A, tap_Di = 0.
  - eng_start = 0, cfg_len = 0.
  - ap_ctrl reads 0x4 (idle).
- Write:
  - Cycle T: awvalid&&wvalid first sampled high.
  - Cycle T+1: awready=wready=1 for exactly one cycle; register/BRAM write is issued in T+1.
  - awvalid without wvalid (or vice versa) waits.
  - Back-to-back writes: minimum 2 cycles apart.
- Read:
  - arvalid sampled at T; arready=1 at T+1 (BRAM address issued at T+1).
  - rvalid=1 at T+2 for all addresses.
  - rvalid and rdata held stable until rready. No arready is issued while rvalid is pending.
- Host tap-port conflict in IDLE: a write and a read issuing in the same cycle -> write wins; arready slips one cycle.
- A read of tap[i] immediately after a write of tap[i] returns the new value.
- Reset mid-RUN: immediate return to IDLE; eng_start=0, cfg_len=0, ap_done=0. BRAM contents are not modified.

## Test plan
- Reset release -> read 0x00 returns 0x4; rvalid two cycles after arvalid; cfg_len=0; no tap_EN activity.
- Write taps 0..10 = {0,-10,-9,23,56,63,56,23,-9,-10,0} -> tap_A steps 0x00..0x28 with tap_WE=4'hF; readback of 0x20..0x48 matches.
- Write 0x10=600, then 0x00=1 -> single eng_start pulse; 0x00 reads 0x1.
  - During RUN: tap_A follows eng_tap_A; a write 0x24=5 does not reach the BRAM; a read of 0x24 returns 0xFFFFFFFF.
- eng_done pulse -> 0x00 reads 0x6, then reads 0x4 on the following read (done cleared); eng_done asserted in IDLE has no effect.
- cfg_len=0, write 0x00=1 -> no eng_start, state stays IDLE, 0x00 reads 0x4.
- Assert axis_rst mid-RUN with rvalid pending and rready low -> rvalid=0 immediately; state IDLE; cfg_len=0; tap coefficients still read back unchanged.

Source files
------------

// File: rtl/fir_ap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_ap_ctrl_if
// Brief    : AXI-Lite configuration bus bundle between the host and the FIR
//            control front end. The master drives requests and the slave
//            answers them.
// Revision : 1.0 - initial release
// ============================================================================
interface fir_ap_ctrl_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  // Write address / write data channels
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  // Read address / read data channels
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/fir_ap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_ap_ctrl
// Brief    : AXI-Lite register front end for the FIR engine. Holds ap_ctrl and
//            data_length, shares the single tap BRAM port between the host and
//            the datapath, and sequences a run with a start pulse and a done
//            handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fir_ap_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  fir_ap_ctrl_if.slave           s_axil,
  // Tap coefficient BRAM port (byte addressed, 1-cycle read latency)
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  // FIR datapath side
  output logic                   eng_start,
  input  logic                   eng_done,
  input  logic                   eng_tap_en,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic [pDATA_WIDTH-1:0] cfg_len
);

  // Register map
  localparam logic [pADDR_WIDTH-1:0] c_ADDR_CTRL   = '0;
  localparam logic [pADDR_WIDTH-1:0] c_ADDR_LEN    = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] c_ADDR_TAP0   = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] c_ADDR_TAPEND = pADDR_WIDTH'(32 + 4 * Tape_Num);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Word-aligned address inside the coefficient window
  function automatic logic f_is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= c_ADDR_TAP0) && (a < c_ADDR_TAPEND) && (a[1:0] == 2'b00);
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_start;

  logic                   r_wr_ack;
  logic [pADDR_WIDTH-1:0] r_waddr;
  logic [pDATA_WIDTH-1:0] r_wdata;

  logic                   r_ar_ack;
  logic [pADDR_WIDTH-1:0] r_raddr;
  logic                   r_rvalid;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic                   r_rd_fresh;
  logic                   r_rd_ctrl;

  logic                   r_ap_done;
  logic                   r_eng_start;
  logic [pDATA_WIDTH-1:0] r_cfg_len;

  logic                   w_wr_go;
  logic                   w_rd_go;
  logic                   w_rd_done;
  logic                   w_rd_tap;
  logic                   w_wr_tap;
  logic [pDATA_WIDTH-1:0] w_rd_val;
  logic [pDATA_WIDTH-1:0] w_ap_ctrl;

  // A write is taken once both channels are valid; the ack cycle blocks an
  // immediate re-take so writes are at least two cycles apart. A read waits
  // while its data is outstanding and yields to a write issuing in the same
  // cycle, so host writes and reads never collide on the BRAM port.
  assign w_wr_go   = s_axil.awvalid && s_axil.wvalid && !r_wr_ack;
  assign w_rd_go   = s_axil.arvalid && !r_ar_ack && !r_rvalid && !w_wr_go;
  assign w_rd_done = r_rvalid && s_axil.rready;
  assign w_rd_tap  = f_is_tap(r_raddr);
  assign w_wr_tap  = f_is_tap(r_waddr);

  assign w_ap_ctrl = {{(pDATA_WIDTH-3){1'b0}},
                      (r_state == S_IDLE), r_ap_done, (r_state == S_RUN)};

  // Bus outputs
  assign s_axil.awready = r_wr_ack;
  assign s_axil.wready  = r_wr_ack;
  assign s_axil.arready = r_ar_ack;
  assign s_axil.rvalid  = r_rvalid;
  // BRAM data is presented directly in the first rvalid cycle, then held
  assign s_axil.rdata   = r_rd_fresh ? tap_Do : r_rdata;

  assign eng_start = r_eng_start;
  assign cfg_len   = r_cfg_len;

  // FSM state register
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; a start request with a zero length is ignored
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_wr_ack && (r_waddr == c_ADDR_CTRL) && r_wdata[0] &&
            (r_cfg_len != '0)) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (eng_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write channel: capture address/data, then ack and commit one cycle later
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_wr_ack <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_wr_ack <= w_wr_go;
      if (w_wr_go) begin
        r_waddr <= s_axil.awaddr;
        r_wdata <= s_axil.wdata;
      end
    end
  end

  // Control registers: data_length is frozen while a run is active
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_cfg_len   <= '0;
      r_eng_start <= 1'b0;
    end else begin
      r_eng_start <= w_start;
      if (r_wr_ack && (r_state == S_IDLE) && (r_waddr == c_ADDR_LEN)) begin
        r_cfg_len <= r_wdata;
      end
    end
  end

  // ap_done: set on run completion (priority), cleared by start or by the
  // host completing a read of ap_ctrl
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_ap_done <= 1'b0;
    end else if ((r_state == S_RUN) && eng_done) begin
      r_ap_done <= 1'b1;
    end else if (w_start) begin
      r_ap_done <= 1'b0;
    end else if (w_rd_done && r_rd_ctrl) begin
      r_ap_done <= 1'b0;
    end
  end

  // Read data selection at the moment the read address is accepted
  always_comb begin
    w_rd_val = '0;
    if (r_raddr == c_ADDR_CTRL) begin
      w_rd_val = w_ap_ctrl;
    end else if (r_raddr == c_ADDR_LEN) begin
      w_rd_val = r_cfg_len;
    end else if (w_rd_tap && (r_state == S_RUN)) begin
      w_rd_val = '1;
    end
  end

  // Read channel: accept address, then hold rvalid/rdata until rready
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_ar_ack   <= 1'b0;
      r_raddr    <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rd_fresh <= 1'b0;
      r_rd_ctrl  <= 1'b0;
    end else begin
      r_ar_ack <= w_rd_go;
      if (w_rd_go) begin
        r_raddr <= s_axil.araddr;
      end
      if (r_ar_ack) begin
        r_rvalid   <= 1'b1;
        r_rd_ctrl  <= (r_raddr == c_ADDR_CTRL);
        r_rd_fresh <= w_rd_tap && (r_state == S_IDLE);
        r_rdata    <= w_rd_val;
      end else begin
        if (r_rd_fresh) begin
          r_rd_fresh <= 1'b0;
          r_rdata    <= tap_Do;
        end
        if (w_rd_done) begin
          r_rvalid  <= 1'b0;
          r_rd_ctrl <= 1'b0;
        end
      end
    end
  end

  // Tap port ownership: datapath passes straight through during a run,
  // otherwise the host write or read being committed this cycle drives it
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (r_state == S_RUN) begin
      tap_EN = eng_tap_en;
      tap_A  = eng_tap_A;
    end else if (r_wr_ack && w_wr_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = r_waddr - c_ADDR_TAP0;
      tap_Di = r_wdata;
    end else if (r_ar_ack && w_rd_tap) begin
      tap_EN = 1'b1;
      tap_A  = r_raddr - c_ADDR_TAP0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_ap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_ap_ctrl
// Brief    : Directed bench for fir_ap_ctrl with a behavioural tap BRAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_ap_ctrl;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_ap_ctrl_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) axil ();

  logic [3:0]    tap_WE;
  logic          tap_EN;
  logic [DW-1:0] tap_Di;
  logic [AW-1:0] tap_A;
  logic [DW-1:0] tap_Do;
  logic          eng_start;
  logic          eng_done;
  logic          eng_tap_en;
  logic [AW-1:0] eng_tap_A;
  logic [DW-1:0] cfg_len;

  fir_ap_ctrl #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(11)) dut (
    .axis_clk   (clk),
    .axis_rst   (rst),
    .s_axil     (axil),
    .tap_WE     (tap_WE),
    .tap_EN     (tap_EN),
    .tap_Di     (tap_Di),
    .tap_A      (tap_A),
    .tap_Do     (tap_Do),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_tap_en (eng_tap_en),
    .eng_tap_A  (eng_tap_A),
    .cfg_len    (cfg_len)
  );

  // Behavioural tap BRAM, 1-cycle read latency
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= mem[tap_A[5:2]];
    end
  end

  // Activity counters sampled mid-cycle
  int n_start = 0;
  int n_we    = 0;
  int n_en    = 0;
  always @(negedge clk) begin
    if (eng_start) n_start++;
    if (tap_WE != 4'h0) n_we++;
    if (tap_EN) n_en++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  int coef [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [3:0] we, output logic en,
                           output logic [AW-1:0] ta, output int lat);
    bit ok;
    ok = 0; lat = 0; we = '0; en = 1'b0; ta = '0;
    axil.awaddr = a; axil.wdata = d; axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    while (!ok && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (axil.awready && axil.wready) begin
        ok = 1; we = tap_WE; en = tap_EN; ta = tap_A;
      end
    end
    if (!ok) timeout("write_handshake");
    @(posedge clk); #1;
    axil.awvalid = 1'b0; axil.wvalid = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [3:0] we; logic en; logic [AW-1:0] ta; int lat;
    axi_write(a, d, we, en, ta, lat);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    bit seen;
    seen = 0; lat = 0; d = '0;
    axil.araddr = a; axil.arvalid = 1'b1;
    while (!axil.rvalid && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (seen) axil.arvalid = 1'b0;
      if (axil.arready) seen = 1;
    end
    axil.arvalid = 1'b0;
    if (!axil.rvalid) begin
      timeout("read_handshake");
    end else begin
      d = axil.rdata;
      axil.rready = 1'b1;
      @(posedge clk); #1;
      axil.rready = 1'b0;
    end
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] d; int lat;
    axi_read(a, d, lat);
    check(tag, d, exp);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [3:0]    we;
    logic          en;
    logic [AW-1:0] ta;
    int            lat;
    int            s0, w0, e0;

    axil.awvalid = 0; axil.awaddr = '0; axil.wvalid = 0; axil.wdata = '0;
    axil.arvalid = 0; axil.araddr = '0; axil.rready = 0;
    eng_done = 0; eng_tap_en = 0; eng_tap_A = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {31'b0, axil.awready}, 32'd0);
    check("rst_wready",  {31'b0, axil.wready},  32'd0);
    check("rst_arready", {31'b0, axil.arready}, 32'd0);
    check("rst_rvalid",  {31'b0, axil.rvalid},  32'd0);
    check("rst_rdata",   axil.rdata, 32'd0);
    check("rst_tap_port", {27'b0, tap_EN, tap_WE}, 32'd0);
    check("rst_tap_A",   {20'b0, tap_A}, 32'd0);
    check("rst_tap_Di",  tap_Di, 32'd0);
    check("rst_eng_start", {31'b0, eng_start}, 32'd0);
    check("rst_cfg_len", cfg_len, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ap_ctrl after reset, read latency, no BRAM activity
    e0 = n_en;
    axi_read(12'h000, d, lat);
    check("rst_ap_ctrl", d, 32'h4);
    check("rd_latency", lat, 32'd2);
    check("rst_no_tap_en", n_en - e0, 32'd0);
    check("rst_cfg_len_after", cfg_len, 32'd0);

    // Coefficient writes: BRAM port per write
    for (int i = 0; i < 11; i++) begin
      axi_write(AW'(32 + 4 * i), coef[i], we, en, ta, lat);
      check($sformatf("tap_wr_port_%0d", i), {15'b0, en, we, ta}, {15'b0, 1'b1, 4'hF, AW'(4 * i)});
      if (i == 0) check("wr_latency", lat, 32'd1);
    end
    for (int i = 0; i < 11; i++) begin
      rd_chk($sformatf("tap_rd_%0d", i), AW'(32 + 4 * i), coef[i]);
    end

    // Read immediately after write of the same tap
    wr(12'h030, 32'd77);
    rd_chk("raw_tap4", 12'h030, 32'd77);
    wr(12'h030, 32'd56);

    // Unmapped address: read zero, write dropped
    wr(12'h100, 32'h12345678);
    rd_chk("unmapped_rd", 12'h100, 32'd0);

    // Simultaneous write and read to the tap range: write first, read slips
    axil.awaddr = 12'h02C; axil.wdata = 32'd99; axil.awvalid = 1; axil.wvalid = 1;
    axil.araddr = 12'h02C; axil.arvalid = 1;
    @(posedge clk); #1;
    check("conf_e1", {30'b0, axil.awready, axil.arready}, 32'b10);
    @(posedge clk); #1;
    axil.awvalid = 0; axil.wvalid = 0;
    check("conf_e2", {30'b0, axil.awready, axil.arready}, 32'b01);
    @(posedge clk); #1;
    axil.arvalid = 0;
    check("conf_rvalid", {31'b0, axil.rvalid}, 32'd1);
    check("conf_rdata", axil.rdata, 32'd99);
    axil.rready = 1;
    @(posedge clk); #1;
    axil.rready = 0;
    wr(12'h02C, 32'd23);
    rd_chk("conf_restore", 12'h02C, 32'd23);

    // Start a run
    wr(12'h010, 32'd600);
    check("cfg_len_600", cfg_len, 32'd600);
    s0 = n_start;
    wr(12'h000, 32'd1);
    check("start_pulse_hi", {31'b0, eng_start}, 32'd1);
    @(posedge clk); #1;
    check("start_pulse_lo", {31'b0, eng_start}, 32'd0);
    check("start_count", n_start - s0, 32'd1);
    rd_chk("run_ap_ctrl", 12'h000, 32'h1);

    // Datapath owns the BRAM port during the run
    eng_tap_en = 1; eng_tap_A = 12'h014;
    #1;
    check("run_tap_pass", {15'b0, tap_EN, tap_WE, tap_A}, {15'b0, 1'b1, 4'h0, 12'h014});
    eng_tap_en = 0; eng_tap_A = '0;
    w0 = n_we;
    wr(12'h024, 32'd5);
    check("run_wr_no_we", n_we - w0, 32'd0);
    check("run_mem_intact", mem[1], 32'hFFFFFFF6);
    rd_chk("run_tap_rd", 12'h024, 32'hFFFFFFFF);
    wr(12'h010, 32'd7);
    check("run_len_frozen", cfg_len, 32'd600);

    // Completion and read-to-clear
    @(posedge clk); #1; eng_done = 1;
    @(posedge clk); #1; eng_done = 0;
    rd_chk("done_ap_ctrl", 12'h000, 32'h6);
    rd_chk("done_cleared", 12'h000, 32'h4);
    @(posedge clk); #1; eng_done = 1;
    @(posedge clk); #1; eng_done = 0;
    rd_chk("idle_done_ignored", 12'h000, 32'h4);
    rd_chk("tap1_after_run", 12'h024, 32'hFFFFFFF6);

    // Zero length start is ignored
    wr(12'h010, 32'd0);
    check("cfg_len_zero", cfg_len, 32'd0);
    s0 = n_start;
    wr(12'h000, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("zero_len_no_start", n_start - s0, 32'd0);
    rd_chk("zero_len_ap_ctrl", 12'h000, 32'h4);

    // Reset in the middle of a run with a read response pending
    wr(12'h010, 32'd600);
    wr(12'h000, 32'd1);
    rd_chk("run2_ap_ctrl", 12'h000, 32'h1);
    axil.araddr = 12'h020; axil.arvalid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    axil.arvalid = 0;
    check("pend_rvalid", {31'b0, axil.rvalid}, 32'd1);
    check("pend_rdata", axil.rdata, 32'hFFFFFFFF);
    eng_tap_en = 1; eng_tap_A = 12'h008;
    #2;
    rst = 1;
    #1;
    check("mid_rst_rvalid", {31'b0, axil.rvalid}, 32'd0);
    check("mid_rst_cfg_len", cfg_len, 32'd0);
    check("mid_rst_start", {31'b0, eng_start}, 32'd0);
    check("mid_rst_tap_en", {31'b0, tap_EN}, 32'd0);
    eng_tap_en = 0; eng_tap_A = '0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rd_chk("post_rst_ap_ctrl", 12'h000, 32'h4);
    for (int i = 0; i < 11; i++) begin
      rd_chk($sformatf("post_rst_tap_%0d", i), AW'(32 + 4 * i), coef[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
